// File: rtl/i2s_stereo_tx.sv
// I2S stereo master transmitter: frame FIFO, sclk/lrclk generation and
// MSB-first serialisation with the standard one-bit data delay.
module i2s_stereo_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i2s,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          mute,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_left,
    input  logic [DATA_WIDTH-1:0]         s_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          tx_mclk,
    output logic                          tx_sclk,
    output logic                          tx_lrclk,
    output logic                          tx_sd
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_HALF  = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0]      SLOT_C    = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0]      DW_C      = BIT_W'(DATA_WIDTH);
    localparam logic [AW:0]           DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ONE_W     = DATA_WIDTH'(1);
    localparam bit                    FULL_SLOT = (DATA_WIDTH == SLOT_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_level;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic                  r_lrclk;
    logic                  r_sd;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_wrap;
    logic                  w_latch;
    logic                  w_pop;
    logic [BIT_W-1:0]      w_nbit;
    logic                  w_rslot;
    logic [BIT_W-1:0]      w_b;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_prev;
    logic                  w_nsd;

    assign w_full  = (r_level == DEPTH_C);
    assign w_empty = (r_level == '0);
    assign w_push  = s_valid && s_ready;
    assign w_wrap  = enable && (r_div == DIV_LAST);
    assign w_latch = w_wrap && (r_bit == BIT_LAST);
    assign w_pop   = w_latch && !w_empty;

    assign s_ready    = !reset && !w_full;
    assign fifo_level = r_level;
    assign underflow  = !reset && w_latch && w_empty;
    assign tx_mclk    = clk_i2s;
    assign tx_sclk    = (r_div >= DIV_HALF);
    assign tx_lrclk   = r_lrclk;
    assign tx_sd      = r_sd;

    // Output bit for the index about to start; slot-bit 0 carries the
    // previous word's LSB only when the word fills the whole slot.
    always_comb begin
        w_nbit  = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
        w_rslot = (w_nbit >= SLOT_C);
        w_b     = w_rslot ? (w_nbit - SLOT_C) : w_nbit;
        w_word  = w_rslot ? r_right : r_left;
        w_prev  = w_rslot ? r_left[0] : r_right[0];
        w_mask  = ONE_W << (DW_C - w_b);
        w_nsd   = 1'b0;
        if (w_b == '0) begin
            w_nsd = FULL_SLOT ? w_prev : 1'b0;
        end else if (w_b <= DW_C) begin
            w_nsd = |(w_word & w_mask);
        end
    end

    always_ff @(posedge clk_i2s) begin
        if (w_push) begin
            r_mem_l[r_wptr] <= s_left;
            r_mem_r[r_wptr] <= s_right;
        end
    end

    always_ff @(posedge clk_i2s) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_lrclk <= 1'b0;
            r_sd    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (w_pop && !w_push) r_level <= r_level - 1'b1;
            if (!enable) begin
                r_div   <= '0;
                r_bit   <= '0;
                r_left  <= '0;
                r_right <= '0;
                r_lrclk <= 1'b0;
                r_sd    <= 1'b0;
            end else begin
                r_div <= w_wrap ? '0 : r_div + 1'b1;
                if (w_wrap) begin
                    r_bit   <= w_nbit;
                    r_lrclk <= w_rslot;
                    r_sd    <= w_nsd;
                end
                if (w_latch) begin
                    if (w_empty || mute) begin
                        r_left  <= '0;
                        r_right <= '0;
                    end else begin
                        r_left  <= r_mem_l[r_rptr];
                        r_right <= r_mem_r[r_rptr];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx: 16-bit default instance plus a
// 32-bit-word instance for the full-slot LSB carry case.
module tb_i2s_stereo_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, mute, valid;
    logic [15:0] l, r;
    logic        ready, uf, mclk, sclk, lr, sd;
    logic [2:0]  lvl;

    logic        rst32, en32, mute32, valid32;
    logic [31:0] l32, r32;
    logic        ready32, uf32, mclk32, sclk32, lr32, sd32;
    logic [2:0]  lvl32;

    logic        sel32;
    logic        m_sclk, m_lr, m_sd, m_uf;
    logic [2:0]  m_lvl;

    assign m_sclk = sel32 ? sclk32 : sclk;
    assign m_lr   = sel32 ? lr32   : lr;
    assign m_sd   = sel32 ? sd32   : sd;
    assign m_uf   = sel32 ? uf32   : uf;
    assign m_lvl  = sel32 ? lvl32  : lvl;

    i2s_stereo_tx dut (
        .clk_i2s(clk), .reset(rst), .enable(en), .mute(mute),
        .s_valid(valid), .s_ready(ready), .s_left(l), .s_right(r),
        .fifo_level(lvl), .underflow(uf), .tx_mclk(mclk),
        .tx_sclk(sclk), .tx_lrclk(lr), .tx_sd(sd)
    );

    i2s_stereo_tx #(.DATA_WIDTH(32)) dut32 (
        .clk_i2s(clk), .reset(rst32), .enable(en32), .mute(mute32),
        .s_valid(valid32), .s_ready(ready32), .s_left(l32), .s_right(r32),
        .fifo_level(lvl32), .underflow(uf32), .tx_mclk(mclk32),
        .tx_sclk(sclk32), .tx_lrclk(lr32), .tx_sd(sd32)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] exp16(input logic [15:0] a,
                                          input logic [15:0] b);
        logic [63:0] e;
        e = '0;
        for (int j = 0; j < 16; j++) begin
            e[1 + j]  = a[15 - j];
            e[33 + j] = b[15 - j];
        end
        return e;
    endfunction

    // Samples one 256-cycle frame starting at bit 0, divider 0.
    task automatic run_frame(input string tag, input logic [63:0] esd,
                             input logic euf, input logic [2:0] elvl);
        logic [63:0] sd_v, lr_v;
        logic        rs, rl, uf_end;
        int          terr;
        sd_v   = '0;
        lr_v   = '0;
        rs     = 1'b0;
        rl     = 1'b0;
        uf_end = 1'b0;
        terr   = 0;
        check({tag, ".lvl"}, 64'(m_lvl), 64'(elvl));
        for (int i = 0; i < 256; i++) begin
            if (i % 4 == 0) begin
                rs = m_sd;
                rl = m_lr;
                sd_v[i / 4] = m_sd;
                lr_v[i / 4] = m_lr;
            end else if (m_sd !== rs || m_lr !== rl) begin
                terr++;
            end
            if (m_sclk !== (i % 4 >= 2)) terr++;
            if (i == 255) uf_end = m_uf;
            else if (m_uf !== 1'b0) terr++;
            tick(1);
        end
        check({tag, ".sd"}, sd_v, esd);
        check({tag, ".lr"}, lr_v, 64'hFFFF_FFFF_0000_0000);
        check({tag, ".uf"}, 64'(uf_end), 64'(euf));
        check({tag, ".timing"}, 64'(terr), 64'h0);
    endtask

    task automatic push16(input logic [15:0] a, input logic [15:0] b);
        valid = 1'b1;
        l = a;
        r = b;
        tick(1);
        valid = 1'b0;
    endtask

    logic [15:0] fl [5];
    logic [15:0] fr [5];

    initial begin
        fl = '{16'hA5F0, 16'h1234, 16'hFFFF, 16'h0001, 16'h7777};
        fr = '{16'h0F0F, 16'h8001, 16'h0000, 16'h8000, 16'h3333};
        rst = 1'b1; en = 1'b0; mute = 1'b0; valid = 1'b0;
        l = '0; r = '0;
        rst32 = 1'b1; en32 = 1'b0; mute32 = 1'b0; valid32 = 1'b0;
        l32 = '0; r32 = '0;
        sel32 = 1'b0;
        tick(3);
        check("rst.ready", 64'(ready), 64'h0);
        rst = 1'b0;
        rst32 = 1'b0;
        #1;
        check("rst.lvl", 64'(lvl), 64'h0);
        check("rst.out", 64'({sclk, lr, sd, uf}), 64'h0);
        check("rst.ready_rel", 64'(ready), 64'h1);
        check("mclk", 64'(mclk), 64'h1);

        // Fill while idle, fifth frame must be refused.
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            l = fl[i];
            r = fr[i];
            #1;
            if (i == 4) check("fill.ready5", 64'(ready), 64'h0);
            tick(1);
        end
        valid = 1'b0;
        check("fill.lvl", 64'(lvl), 64'h4);
        check("idle.out", 64'({sclk, lr, sd}), 64'h0);
        en = 1'b1;
        run_frame("f0", 64'h0, 1'b0, 3'd4);
        check("f0.ready", 64'(ready), 64'h1);
        run_frame("f1", exp16(fl[0], fr[0]), 1'b0, 3'd3);
        run_frame("f2", exp16(fl[1], fr[1]), 1'b0, 3'd2);
        run_frame("f3", exp16(fl[2], fr[2]), 1'b0, 3'd1);
        run_frame("f4", exp16(fl[3], fr[3]), 1'b1, 3'd0);
        run_frame("f5", 64'h0, 1'b1, 3'd0);

        // Mute drains the queue without sending data.
        en = 1'b0;
        tick(1);
        push16(16'h1111, 16'h2222);
        push16(16'h3333, 16'h4444);
        push16(16'h5555, 16'h6666);
        mute = 1'b1;
        en = 1'b1;
        run_frame("m0", 64'h0, 1'b0, 3'd3);
        run_frame("m1", 64'h0, 1'b0, 3'd2);
        run_frame("m2", 64'h0, 1'b0, 3'd1);
        run_frame("m3", 64'h0, 1'b1, 3'd0);
        mute = 1'b0;

        // Reset in the middle of a frame with two frames queued.
        en = 1'b0;
        tick(1);
        push16(16'hDEAD, 16'hBEEF);
        push16(16'hCAFE, 16'hF00D);
        en = 1'b1;
        tick(160);
        check("b40.lr", 64'(lr), 64'h1);
        rst = 1'b1;
        tick(1);
        check("mid.out", 64'({sclk, lr, sd, uf}), 64'h0);
        check("mid.lvl", 64'(lvl), 64'h0);
        check("mid.ready", 64'(ready), 64'h0);
        rst = 1'b0;
        run_frame("r0", 64'h0, 1'b1, 3'd0);

        // Push landing on the latch cycle is not seen by that latch.
        tick(255);
        check("nb.uf", 64'(uf), 64'h1);
        push16(16'hC3A5, 16'h5A3C);
        check("nb.lvl", 64'(lvl), 64'h1);
        run_frame("nb0", 64'h0, 1'b0, 3'd1);
        run_frame("nb1", exp16(16'hC3A5, 16'h5A3C), 1'b1, 3'd0);

        // Full-slot words carry the LSB into the next slot's bit 0.
        en = 1'b0;
        sel32 = 1'b1;
        valid32 = 1'b1;
        l32 = 32'h0000_0001;
        r32 = 32'h0000_0000;
        tick(1);
        l32 = 32'h8000_0000;
        r32 = 32'h0000_0003;
        tick(1);
        valid32 = 1'b0;
        en32 = 1'b1;
        run_frame("w0", 64'h0, 1'b0, 3'd2);
        run_frame("w1", 64'h0000_0001_0000_0000, 1'b0, 3'd1);
        run_frame("w2", 64'h8000_0000_0000_0002, 1'b1, 3'd0);
        run_frame("w3", 64'h0000_0000_0000_0001, 1'b1, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
